decode_execute_stage: RTL and testbench

RV64I integer decode/execute block for the in-order core. It accepts one 32-bit instruction per cycle from the fetch path and decodes it. It reads operands from a 32×64 register file, executes the ALU/branch operation, and writes the result back. Memory, CSR and fetch logic are outside this block; it reports control-flow redirects and a halt condition to the fetch side.

---
 rtl/decode_execute_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_decode_execute_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// RV64I decode/execute block: decode register with execute-result bypass, combinational
// execute, registered writeback/result/redirect, and a sticky halt on an all-zero instruction.
module decode_execute_stage #(
  localparam int unsigned REGISTER_WIDTH        = 64,
  localparam int unsigned REGISTER_NUMBER_WIDTH = 5,
  localparam int unsigned INSTRUCTION_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             instr_valid,
  input  logic [INSTRUCTION_WIDTH-1:0]     instr,
  input  logic [REGISTER_WIDTH-1:0]        instr_pc,
  input  logic [REGISTER_NUMBER_WIDTH-1:0] dbg_raddr,
  output logic [REGISTER_WIDTH-1:0]        dbg_rdata,
  output logic                             result_valid,
  output logic [REGISTER_WIDTH-1:0]        result,
  output logic [REGISTER_NUMBER_WIDTH-1:0] result_rd,
  output logic [REGISTER_WIDTH-1:0]        result_pc,
  output logic [REGISTER_WIDTH-1:0]        store_data,
  output logic                             is_load,
  output logic                             is_store,
  output logic                             redirect,
  output logic [REGISTER_WIDTH-1:0]        redirect_pc,
  output logic                             illegal,
  output logic                             halt
);
  localparam int unsigned XLEN     = REGISTER_WIDTH;
  localparam int unsigned RIDX     = REGISTER_NUMBER_WIDTH;
  localparam int unsigned NUM_REGS = 1 << REGISTER_NUMBER_WIDTH;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  logic [XLEN-1:0] regs [NUM_REGS];

  logic                         d_valid;
  logic [INSTRUCTION_WIDTH-1:0] d_instr;
  logic [XLEN-1:0]              d_pc, d_rs1, d_rs2;

  logic                         accept, ex_valid;
  logic [RIDX-1:0]              rs1_idx, rs2_idx;
  logic [XLEN-1:0]              rs1_val, rs2_val;

  logic [XLEN-1:0]              ex_result, ex_target, ex_sd;
  logic [RIDX-1:0]              ex_rd;
  logic                         ex_redirect, ex_load, ex_store, ex_illegal, br_taken;

  logic [6:0]                   opcode, funct7;
  logic [2:0]                   funct3;
  logic [RIDX-1:0]              rd;
  logic [XLEN-1:0]              imm_i, imm_s, imm_b, imm_u, imm_j;

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[5:0];
      3'b010:  return {63'b0, $signed(a) < $signed(b)};
      3'b011:  return {63'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? $unsigned($signed(a) >>> b[5:0]) : a >> b[5:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // 32-bit ops: result sign-extended from bit 31
  function automatic logic [XLEN-1:0] aluw(input logic [2:0] f3, input logic alt,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
      3'b001:  r = a[31:0] << b[4:0];
      3'b101:  r = alt ? $unsigned($signed(a[31:0]) >>> b[4:0]) : a[31:0] >> b[4:0];
      default: r = '0;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

  // Decode-side operand read; the instruction in execute forwards its result
  assign accept  = instr_valid && !redirect && !halt;
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];

  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (rs1_idx != '0 && ex_rd == rs1_idx) rs1_val = ex_result;
    if (rs2_idx != '0 && ex_rd == rs2_idx) rs2_val = ex_result;
    if (rs1_idx == '0) rs1_val = '0;
    if (rs2_idx == '0) rs2_val = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid <= 1'b0;
      d_instr <= '0;
      d_pc    <= '0;
      d_rs1   <= '0;
      d_rs2   <= '0;
      halt    <= 1'b0;
    end else begin
      d_valid <= accept && (instr != '0);
      if (accept) begin
        d_instr <= instr;
        d_pc    <= instr_pc;
        d_rs1   <= rs1_val;
        d_rs2   <= rs2_val;
      end
      if (accept && instr == '0) halt <= 1'b1;
    end
  end

  // Execute: the decode-register instruction is squashed while a redirect is out
  assign ex_valid = d_valid && !redirect;
  assign opcode   = d_instr[6:0];
  assign funct3   = d_instr[14:12];
  assign funct7   = d_instr[31:25];
  assign rd       = d_instr[11:7];
  assign imm_i    = {{52{d_instr[31]}}, d_instr[31:20]};
  assign imm_s    = {{52{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
  assign imm_b    = {{51{d_instr[31]}}, d_instr[31], d_instr[7], d_instr[30:25], d_instr[11:8], 1'b0};
  assign imm_u    = {{32{d_instr[31]}}, d_instr[31:12], 12'b0};
  assign imm_j    = {{43{d_instr[31]}}, d_instr[31], d_instr[19:12], d_instr[20], d_instr[30:21], 1'b0};

  always_comb begin
    ex_result   = '0;
    ex_rd       = '0;
    ex_redirect = 1'b0;
    ex_target   = '0;
    ex_load     = 1'b0;
    ex_store    = 1'b0;
    ex_sd       = '0;
    ex_illegal  = 1'b0;
    br_taken    = 1'b0;
    if (ex_valid) begin
      case (opcode)
        OPC_LUI:   begin ex_result = imm_u;        ex_rd = rd; end
        OPC_AUIPC: begin ex_result = d_pc + imm_u; ex_rd = rd; end
        OPC_JAL: begin
          ex_result   = d_pc + 64'd4;
          ex_rd       = rd;
          ex_redirect = 1'b1;
          ex_target   = d_pc + imm_j;
        end
        OPC_JALR: begin
          if (funct3 == 3'b000) begin
            ex_result   = d_pc + 64'd4;
            ex_rd       = rd;
            ex_redirect = 1'b1;
            ex_target   = (d_rs1 + imm_i) & ~64'd1;
          end else ex_illegal = 1'b1;
        end
        OPC_BRANCH: begin
          case (funct3)
            3'b000:  br_taken = d_rs1 == d_rs2;
            3'b001:  br_taken = d_rs1 != d_rs2;
            3'b100:  br_taken = $signed(d_rs1) < $signed(d_rs2);
            3'b101:  br_taken = $signed(d_rs1) >= $signed(d_rs2);
            3'b110:  br_taken = d_rs1 < d_rs2;
            3'b111:  br_taken = d_rs1 >= d_rs2;
            default: ex_illegal = 1'b1;
          endcase
          ex_redirect = br_taken;
          ex_target   = br_taken ? d_pc + imm_b : '0;
        end
        OPC_LOAD: begin
          if (funct3 != 3'b111) begin
            ex_result = d_rs1 + imm_i;
            ex_load   = 1'b1;
          end else ex_illegal = 1'b1;
        end
        OPC_STORE: begin
          if (!funct3[2]) begin
            ex_result = d_rs1 + imm_s;
            ex_store  = 1'b1;
            ex_sd     = d_rs2;
          end else ex_illegal = 1'b1;
        end
        OPC_OP_IMM: begin
          if ((funct3 == 3'b001 && d_instr[31:26] != 6'b000000) ||
              (funct3 == 3'b101 && d_instr[31:26] != 6'b000000 && d_instr[31:26] != 6'b010000))
            ex_illegal = 1'b1;
          else begin
            ex_result = alu(funct3, funct3 == 3'b101 && d_instr[30], d_rs1, imm_i);
            ex_rd     = rd;
          end
        end
        OPC_OP: begin
          if (funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
            ex_result = alu(funct3, d_instr[30], d_rs1, d_rs2);
            ex_rd     = rd;
          end else ex_illegal = 1'b1;
        end
        OPC_OP_IMM32: begin
          if (funct3 == 3'b000 || (funct3 == 3'b001 && funct7 == 7'b0000000) ||
              (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))) begin
            ex_result = aluw(funct3, funct3 == 3'b101 && d_instr[30], d_rs1, imm_i);
            ex_rd     = rd;
          end else ex_illegal = 1'b1;
        end
        OPC_OP32: begin
          if ((funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101) &&
              (funct7 == 7'b0000000 ||
               (funct7 == 7'b0100000 && funct3 != 3'b001))) begin
            ex_result = aluw(funct3, d_instr[30], d_rs1, d_rs2);
            ex_rd     = rd;
          end else ex_illegal = 1'b1;
        end
        OPC_FENCE:  ex_illegal = funct3 != 3'b000;
        OPC_SYSTEM: ex_illegal = d_instr != INSN_ECALL && d_instr != INSN_EBREAK;
        default:    ex_illegal = 1'b1;
      endcase
    end
  end

  // Register file; x0 is never written because ex_rd is 0 for it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs <= '{default: '0};
    else if (ex_rd != '0) regs[ex_rd] <= ex_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid <= 1'b0;
      result       <= '0;
      result_rd    <= '0;
      result_pc    <= '0;
      store_data   <= '0;
      is_load      <= 1'b0;
      is_store     <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      illegal      <= 1'b0;
    end else begin
      result_valid <= ex_valid;
      result       <= ex_result;
      result_rd    <= ex_rd;
      result_pc    <= ex_valid ? d_pc : '0;
      store_data   <= ex_sd;
      is_load      <= ex_load;
      is_store     <= ex_store;
      redirect     <= ex_redirect;
      redirect_pc  <= ex_target;
      illegal      <= ex_illegal;
    end
  end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: stimulus queues expected completions, a negedge
// monitor pops and compares them whenever result_valid is seen.
module tb_decode_execute_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] instr_pc = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [63:0] dbg_rdata, result, result_pc, store_data, redirect_pc;
  logic [4:0]  result_rd;
  logic        result_valid, is_load, is_store, redirect, illegal, halt;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic        redir;
    logic [63:0] rpc;
    logic        ill;
    logic        ld;
    logic        st;
    logic [63:0] sd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  decode_execute_stage dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .result_valid(result_valid), .result(result),
    .result_rd(result_rd), .result_pc(result_pc), .store_data(store_data), .is_load(is_load),
    .is_store(is_store), .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal),
    .halt(halt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [63:0] res, input logic [4:0] rd, input logic [63:0] pc,
                              input logic redir, input logic [63:0] rpc, input logic ill,
                              input logic ld, input logic st, input logic [63:0] sd);
    exp_t e;
    e = '{res: res, rd: rd, pc: pc, redir: redir, rpc: rpc, ill: ill, ld: ld, st: st, sd: sd};
    return e;
  endfunction

  function automatic exp_t alu_e(input logic [63:0] res, input logic [4:0] rd, input logic [63:0] pc);
    return mk(res, rd, pc, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input logic [4:0] idx, input logic [63:0] exp);
    dbg_raddr = idx;
    #1;
    chk($sformatf("reg_x%0d", idx), dbg_rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle; push its completion if one is expected
  task automatic issue(input logic [31:0] i, input logic [63:0] pc, input logic push, input exp_t e);
    instr_valid = 1'b1;
    instr       = i;
    instr_pc    = pc;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e, got;
    if (reset && result_valid) begin
      got = mk(result, result_rd, result_pc, redirect, redirect_pc, illegal, is_load, is_store, store_data);
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_result: got pc %h result %h rd %0d, expected no completion",
                 result_pc, result, result_rd);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL txn_pc_%h: got res %h rd %0d pc %h redir %b rpc %h ill %b ld %b st %b sd %h; expected res %h rd %0d pc %h redir %b rpc %h ill %b ld %b st %b sd %h",
                   e.pc, got.res, got.rd, got.pc, got.redir, got.rpc, got.ill, got.ld, got.st, got.sd,
                   e.res, e.rd, e.pc, e.redir, e.rpc, e.ill, e.ld, e.st, e.sd);
        end
      end
    end else if (reset && redirect) begin
      n_errors++;
      $display("FAIL stray_redirect: got redirect 1 without result_valid, expected 0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    idle(2);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_rd", result_rd, 0);
    chk("rst_result_pc", result_pc, 0);
    chk("rst_store_data", store_data, 0);
    chk("rst_mem_flags", {is_load, is_store}, 0);
    chk("rst_redirect", {redirect, illegal, halt}, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk_reg(5'd5, 64'd0);
    reset = 1'b1;
    idle(1);

    issue(32'h0050_0093, 64'h1000, 1'b1, alu_e(64'd5, 5'd1, 64'h1000));      // ADDI x1,x0,5
    idle(3);
    chk_reg(5'd1, 64'd5);

    issue(32'h0090_0093, 64'h1004, 1'b1, alu_e(64'd9, 5'd1, 64'h1004));      // ADDI x1,x0,9
    issue(32'h0050_0093, 64'h1008, 1'b1, alu_e(64'd5, 5'd1, 64'h1008));      // ADDI x1,x0,5
    issue(32'h0010_8133, 64'h100c, 1'b1, alu_e(64'd10, 5'd2, 64'h100c));     // ADD x2,x1,x1
    issue(32'h8000_01b7, 64'h1010, 1'b1, alu_e(64'hFFFF_FFFF_8000_0000, 5'd3, 64'h1010)); // LUI
    issue(32'hFFF1_821B, 64'h1014, 1'b1, alu_e(64'h0000_0000_7FFF_FFFF, 5'd4, 64'h1014)); // ADDIW
    issue(32'h4010_02B3, 64'h1018, 1'b1, alu_e(64'hFFFF_FFFF_FFFF_FFFB, 5'd5, 64'h1018)); // SUB
    issue(32'h4012_D313, 64'h101c, 1'b1, alu_e(64'hFFFF_FFFF_FFFF_FFFD, 5'd6, 64'h101c)); // SRAI
    issue(32'h0020_B423, 64'h1020, 1'b1, mk(64'd13, 5'd0, 64'h1020, 0, 0, 0, 0, 1, 64'd10)); // SD
    issue(32'hFFC1_3403, 64'h1024, 1'b1, mk(64'd6, 5'd0, 64'h1024, 0, 0, 0, 1, 0, 64'd0));   // LD
    issue(32'hFFFF_FFFF, 64'h1028, 1'b1, mk(64'd0, 5'd0, 64'h1028, 0, 0, 1, 0, 0, 64'd0));   // illegal
    idle(3);
    chk_reg(5'd2, 64'd10);
    chk_reg(5'd4, 64'h0000_0000_7FFF_FFFF);
    chk_reg(5'd8, 64'd0);

    // Taken BEQ: follower squashed, instruction during redirect ignored
    issue(32'h0000_0463, 64'h2000, 1'b1, mk(64'd0, 5'd0, 64'h2000, 1, 64'h2008, 0, 0, 0, 64'd0));
    issue(32'h0070_0093, 64'h2004, 1'b0, '0);
    issue(32'h0070_0093, 64'h2004, 1'b0, '0);
    issue(32'h0030_0513, 64'h2008, 1'b1, alu_e(64'd3, 5'd10, 64'h2008));     // ADDI x10,x0,3
    idle(3);
    chk_reg(5'd1, 64'd5);
    chk_reg(5'd10, 64'd3);

    issue(32'h0000_1463, 64'h2400, 1'b1, alu_e(64'd0, 5'd0, 64'h2400));      // BNE not taken
    issue(32'h0100_00EF, 64'h3000, 1'b1, mk(64'h3004, 5'd1, 64'h3000, 1, 64'h3010, 0, 0, 0, 64'd0)); // JAL
    issue(32'h0070_0093, 64'h3004, 1'b0, '0);
    idle(3);
    issue(32'h0045_05E7, 64'h4000, 1'b1, mk(64'h4004, 5'd11, 64'h4000, 1, 64'h6, 0, 0, 0, 64'd0)); // JALR
    idle(3);
    chk_reg(5'd1, 64'h3004);
    chk_reg(5'd11, 64'h4004);

    issue(32'h0010_0013, 64'h4800, 1'b1, alu_e(64'd1, 5'd0, 64'h4800));      // ADDI x0,x0,1
    idle(3);
    chk_reg(5'd0, 64'd0);

    issue(32'h0000_0000, 64'h4804, 1'b0, '0);
    issue(32'h0070_0093, 64'h4808, 1'b0, '0);
    idle(3);
    chk("halt_sticky", halt, 1);
    chk_reg(5'd1, 64'h3004);

    // Reset clears halt and registers, and discards an in-flight instruction
    reset = 1'b0;
    idle(1);
    chk("halt_after_reset", halt, 0);
    chk_reg(5'd1, 64'd0);
    reset = 1'b1;
    idle(1);
    issue(32'h0050_0093, 64'h5000, 1'b0, '0);
    reset = 1'b0;
    #1;
    chk("inflight_discard_valid", result_valid, 0);
    idle(2);
    reset = 1'b1;
    idle(3);
    chk_reg(5'd1, 64'd0);
    issue(32'h0050_0093, 64'h5004, 1'b1, alu_e(64'd5, 5'd1, 64'h5004));
    idle(4);
    chk_reg(5'd1, 64'd5);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
